// File: rtl/encoder8_3_sync.sv
// Debounced 8-to-3 priority encoder: a request pattern must hold for STABLE_CNT
// sampling edges before its index is presented, held until acknowledged.
module encoder8_3_sync #(
    parameter int unsigned STABLE_CNT = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] in_code,
    input  logic       code_ack,
    output logic [2:0] out_code,
    output logic       out_valid,
    output logic       out_err
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FILTER   = 2'd1;
    localparam logic [1:0] VALID    = 2'd2;
    localparam logic [1:0] WAIT_REL = 2'd3;

    localparam logic [7:0] STABLE_TARGET = 8'(STABLE_CNT);

    logic [1:0] state;
    logic [7:0] snapshot;
    logic [7:0] cnt;
    logic [7:0] cnt_next;

    // Bit 7 has the highest priority, so the last set bit scanned wins.
    function automatic logic [2:0] hi_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic multi_bit(input logic [7:0] v);
        return (v & (v - 8'd1)) != 8'd0;
    endfunction

    assign cnt_next = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // NOTE: all state here uses non-blocking assignments so every register
    // updates from the same pre-edge values, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            snapshot  <= 8'd0;
            cnt       <= 8'd0;
            out_code  <= 3'd0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_code != 8'd0) begin
                        snapshot <= in_code;
                        cnt      <= 8'd1;
                        if (STABLE_TARGET == 8'd1) begin
                            state     <= VALID;
                            out_code  <= hi_index(in_code);
                            out_err   <= multi_bit(in_code);
                            out_valid <= 1'b1;
                        end else begin
                            state <= FILTER;
                        end
                    end
                end

                FILTER: begin
                    if (in_code == 8'd0) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (in_code != snapshot) begin
                        snapshot <= in_code;
                        cnt      <= 8'd1;
                    end else begin
                        cnt <= cnt_next;
                        if (cnt_next == STABLE_TARGET) begin
                            state     <= VALID;
                            out_code  <= hi_index(snapshot);
                            out_err   <= multi_bit(snapshot);
                            out_valid <= 1'b1;
                        end
                    end
                end

                VALID: begin
                    if (code_ack) begin
                        state     <= WAIT_REL;
                        out_valid <= 1'b0;
                    end
                end

                WAIT_REL: begin
                    // A held request must be released before it can be re-encoded.
                    if (in_code == 8'd0) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder8_3_sync.sv
// Self-checking bench: two instances (STABLE_CNT 4 and 1) share directed and
// random stimulus and are compared every cycle against a run-length model.
module tb_encoder8_3_sync;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] in_code;
    logic       code_ack;

    logic [2:0] code4, code1;
    logic       valid4, valid1;
    logic       err4, err1;

    int n_cmp = 0;
    int n_bad = 0;

    encoder8_3_sync #(.STABLE_CNT(4)) dut4 (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .in_code  (in_code),
        .code_ack (code_ack),
        .out_code (code4),
        .out_valid(valid4),
        .out_err  (err4)
    );

    encoder8_3_sync #(.STABLE_CNT(1)) dut1 (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .in_code  (in_code),
        .code_ack (code_ack),
        .out_code (code1),
        .out_valid(valid1),
        .out_err  (err1)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Model view: a nonzero value is tracked by how many consecutive edges it
    // has been seen; reaching the threshold raises a pending code, and after it
    // is acknowledged nothing new is counted until the lines go quiet.
    typedef struct packed {
        logic       pending;
        logic       blocked;
        logic [7:0] run_val;
        logic [8:0] run_len;
        logic [2:0] code;
        logic       err;
    } model_t;

    model_t m4, m1;

    function automatic model_t model_step(input model_t m, input int stable,
                                          input logic [7:0] v, input logic ack,
                                          input logic rst);
        model_t r;
        r = m;
        if (rst) begin
            r = '0;
        end else if (r.pending) begin
            if (ack) begin
                r.pending = 1'b0;
                r.blocked = 1'b1;
            end
        end else if (r.blocked) begin
            if (v == 8'd0) begin
                r.blocked = 1'b0;
                r.run_len = 9'd0;
            end
        end else if (v == 8'd0) begin
            r.run_len = 9'd0;
        end else begin
            if (r.run_len != 9'd0 && v == r.run_val) begin
                r.run_len = r.run_len + 9'd1;
            end else begin
                r.run_val = v;
                r.run_len = 9'd1;
            end
            if (int'(r.run_len) == stable) begin
                r.pending = 1'b1;
                r.code    = 3'($clog2(int'(v) + 1) - 1);
                r.err     = ($countones(v) > 1);
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " valid4"}, 8'(valid4), 8'(m4.pending));
        check({tag, " code4"},  8'(code4),  8'(m4.code));
        check({tag, " err4"},   8'(err4),   8'(m4.err));
        check({tag, " valid1"}, 8'(valid1), 8'(m1.pending));
        check({tag, " code1"},  8'(code1),  8'(m1.code));
        check({tag, " err1"},   8'(err1),   8'(m1.err));
    endtask

    // Drive one cycle: inputs set after the falling edge, model advanced on the
    // rising edge, outputs checked at the next falling edge.
    task automatic step(input string tag, input logic [7:0] v, input logic ack, input logic rst);
        sys_rst  = rst;
        in_code  = v;
        code_ack = ack;
        @(posedge sys_clk);
        m4 = model_step(m4, 4, v, ack, rst);
        m1 = model_step(m1, 1, v, ack, rst);
        @(negedge sys_clk);
        check_all(tag);
    endtask

    task automatic hold(input string tag, input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) step(tag, v, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] v;
        int         len;
        int         kind;

        m4 = '0;
        m1 = '0;
        sys_rst  = 1'b1;
        in_code  = 8'd0;
        code_ack = 1'b0;
        @(negedge sys_clk);

        step("reset", 8'h00, 1'b0, 1'b1);
        step("reset", 8'h00, 1'b0, 1'b1);

        // One-hot held: code 2 appears after the fourth edge.
        hold("onehot2", 8'h04, 3);
        check("onehot2 not yet", 8'(valid4), 8'd0);
        hold("onehot2", 8'h04, 1);
        check("onehot2 lat valid", 8'(valid4), 8'd1);
        check("onehot2 lat code", 8'(code4), 8'd2);
        step("onehot2 ack", 8'h04, 1'b1, 1'b0);
        hold("onehot2 rel", 8'h00, 2);

        // Short pulse never qualifies.
        hold("short", 8'h10, 2);
        hold("short", 8'h00, 3);
        check("short valid", 8'(valid4), 8'd0);

        // Multi-hot: highest bit wins, error flagged.
        hold("multi", 8'h82, 4);
        check("multi code", 8'(code4), 8'd7);
        check("multi err", 8'(err4), 8'd1);
        step("multi change ignored", 8'h01, 1'b0, 1'b0);
        step("multi ack+change", 8'h20, 1'b1, 1'b0);
        check("multi after ack", 8'(valid4), 8'd0);
        check("multi retained", 8'(code4), 8'd7);
        hold("multi held", 8'h20, 6);
        hold("multi rel", 8'h00, 1);

        // Held input gives one valid; ack, re-arm needs release then four edges.
        hold("rearm", 8'h01, 4);
        step("rearm wait", 8'h01, 1'b0, 1'b0);
        step("rearm ack", 8'h01, 1'b1, 1'b0);
        hold("rearm held", 8'h01, 5);
        check("rearm no second", 8'(valid4), 8'd0);
        hold("rearm zero", 8'h00, 1);
        hold("rearm again", 8'h01, 4);
        check("rearm second valid", 8'(valid4), 8'd1);
        step("rearm ack2", 8'h01, 1'b1, 1'b0);
        hold("rearm rel", 8'h00, 1);

        // Value change restarts the stability count.
        hold("restart", 8'h01, 2);
        hold("restart", 8'h02, 3);
        check("restart early", 8'(valid4), 8'd0);
        hold("restart", 8'h02, 1);
        check("restart valid", 8'(valid4), 8'd1);
        check("restart code", 8'(code4), 8'd1);

        // Reset discards a pending code.
        step("rst pending", 8'h02, 1'b0, 1'b1);
        check("rst valid", 8'(valid4), 8'd0);
        check("rst code", 8'(code4), 8'd0);
        check("rst err", 8'(err4), 8'd0);
        hold("rst after", 8'h02, 3);
        check("rst restart", 8'(valid4), 8'd0);
        hold("rst after", 8'h02, 1);
        hold("rst rel", 8'h00, 2);

        // Randomized runs with random acks and occasional reset.
        for (int n = 0; n < 600; n++) begin
            kind = int'($urandom_range(0, 99));
            if (kind < 25)      v = 8'h00;
            else if (kind < 70) v = 8'(1 << $urandom_range(0, 7));
            else                v = 8'($urandom_range(1, 255));
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                step("rand", v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/encoder8_3_sync.md
ENCODER8_3_SYNC -- requirements
Module: encoder8_3_sync

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, number of consecutive sampling edges the input must hold one value before encoding (legal 1..255).
REQ-002 SHALL have port sys_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_code  input  8  raw request lines, nominally one-hot, bit i = request i; no synchronizer inside, treated as synchronous to sys_clk.
REQ-005 SHALL have port code_ack  input  1  consumer accepts the presented code.
REQ-006 SHALL have port out_code  output  3  encoded index, registered.
REQ-007 SHALL have port out_valid  output  1  out_code/out_err valid, held until acknowledged.
REQ-008 SHALL have port out_err  output  1  captured value had more than one bit set.

Function
REQ-009 SHALL implement FSM states IDLE, FILTER, VALID, WAIT_REL, plus an 8-bit snapshot register and an 8-bit saturating stability counter cnt.
REQ-010 IDLE: in_code==0 -> stay; in_code!=0 -> snapshot=in_code, cnt=1, go FILTER; if STABLE_CNT==1, go directly to VALID instead.
REQ-011 FILTER: in_code==0 -> IDLE; in_code!=snapshot and nonzero -> snapshot=in_code, cnt=1, stay; in_code==snapshot -> cnt+1.
REQ-012 FILTER: on the edge where in_code==snapshot and cnt+1==STABLE_CNT, SHALL go VALID and register out_code, out_err, and out_valid=1 on that same edge.
REQ-013 Latency: with V first sampled at edge k and held, out_valid SHALL be high after edge k+STABLE_CNT-1.
REQ-014 out_code SHALL be the index of the highest set bit of snapshot (priority: bit 7 highest).
REQ-015 out_err SHALL be 1 iff popcount(snapshot)>1.
REQ-016 VALID: out_valid, out_code, out_err SHALL be held constant; in_code changes ignored.
REQ-017 VALID with code_ack sampled high -> out_valid=0 on that edge, go WAIT_REL; out_code/out_err retain last value.
REQ-018 code_ack while not in VALID SHALL be ignored.
REQ-019 WAIT_REL: stay until in_code==0 sampled, then IDLE; a held input SHALL produce exactly one out_valid.
REQ-020 Simultaneous code_ack and in_code change in VALID: ack processed, change ignored.
REQ-021 cnt SHALL saturate at 255 and never wrap.

Reset
REQ-022 With sys_rst high at a rising edge: state=IDLE, cnt=0, snapshot=0, out_code=0, out_valid=0, out_err=0, taking effect after that edge.
REQ-023 Reset in any state, including VALID with an unacknowledged code, SHALL discard the pending code without asserting out_valid again.
REQ-024 sys_rst SHALL take priority over all other inputs on the same edge.

Verification (STABLE_CNT=4)
REQ-025 in_code=8'b0000_0100 held from edge k -> out_valid=1 after edge k+3, out_code=3'd2, out_err=0.
REQ-026 in_code=8'h10 for 2 edges, then 8'h00 -> out_valid stays 0 throughout.
REQ-027 in_code=8'b1000_0010 held -> out_code=3'd7, out_err=1.
REQ-028 in_code=8'h01 held, code_ack=1 one cycle after out_valid -> out_valid=0 next edge, no second out_valid until in_code=0 then 8'h01 held 4 more edges.
REQ-029 in_code=8'h01 for 2 edges then 8'h02 held -> out_valid after 4th edge of 8'h02, out_code=3'd1.
REQ-030 sys_rst=1 while out_valid=1 -> after that edge out_valid=0, out_code=0, out_err=0, FSM in IDLE.
